// File: rtl/vp_frame_ctrl.sv
// Frame sequencer between the HDMI source and the vp pipeline: 1-cycle delay, whole-frame de gating,
// geometry measurement. Define VP_FRAME_SKIP_EN to add skip_n (frame skipping in continuous mode).
module vp_frame_ctrl #(
    parameter int unsigned EXP_W = 64,
    parameter int unsigned EXP_H = 64,
    parameter int unsigned CW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          de_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          start,
    input  logic          stop,
    input  logic          cont,
`ifdef VP_FRAME_SKIP_EN
    input  logic [3:0]    skip_n,
`endif
    output logic          de_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_err,
    output logic [CW-1:0] meas_w,
    output logic [CW-1:0] meas_h,
    output logic [15:0]   frame_cnt
);

    localparam logic [CW-1:0] CntMax = {CW{1'b1}};
    localparam logic [CW-1:0] ExpW   = CW'(EXP_W);
    localparam logic [CW-1:0] ExpH   = CW'(EXP_H);

`ifdef VP_FRAME_SKIP_EN
    typedef enum logic [2:0] {StIdle, StArm, StRun, StStopping, StSkip} state_e;
`else
    typedef enum logic [1:0] {StIdle, StArm, StRun, StStopping} state_e;
`endif

    state_e state_q, state_d;

    logic          vs_q, hs_q, de_q;
    logic          cont_q;
    logic          vs_rise;
    logic          gate;
    logic          acc_clr;
    logic          frame_end;
    logic [CW-1:0] pix_cnt_q, line_cnt_q, w_acc_q;
    logic [CW-1:0] meas_w_q, meas_h_q;
    logic          de_out_q, frame_done_q, frame_err_q;
    logic [15:0]   frame_cnt_q;

`ifdef VP_FRAME_SKIP_EN
    logic [3:0]    skip_n_q, skip_cnt_q;
    logic          stop_pend_q;
    logic          skip_load, skip_dec;
`endif

    assign vs_rise = vs_in & ~vs_q;

    always_comb begin
        state_d   = state_q;
        gate      = 1'b0;
        acc_clr   = 1'b0;
        frame_end = 1'b0;
`ifdef VP_FRAME_SKIP_EN
        skip_load = 1'b0;
        skip_dec  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StArm;
            end
            StArm: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (vs_rise) begin
                    state_d = StRun;
                    acc_clr = 1'b1;
                end
            end
            StRun, StStopping: begin
                gate = 1'b1;
                if (vs_rise) begin
                    frame_end = 1'b1;
                    acc_clr   = 1'b1;
                    state_d   = StIdle;
                    // A stop coinciding with completion still ends the session here.
                    if (state_q == StRun && cont_q && !stop) begin
`ifdef VP_FRAME_SKIP_EN
                        if (skip_n_q != 4'd0) begin
                            state_d   = StSkip;
                            skip_load = 1'b1;
                        end else begin
                            state_d = StRun;
                        end
`else
                        state_d = StRun;
`endif
                    end
                end else if (state_q == StRun && stop) begin
                    state_d = StStopping;
                end
            end
`ifdef VP_FRAME_SKIP_EN
            StSkip: begin
                if (vs_rise) begin
                    if (stop_pend_q || stop) begin
                        state_d = StIdle;
                    end else if (skip_cnt_q <= 4'd1) begin
                        state_d = StRun;
                        acc_clr = 1'b1;
                    end else begin
                        skip_dec = 1'b1;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) cont_q <= cont;
        end
    end

    // Raw delay line; hs/vs are never gated.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q     <= 1'b0;
            hs_q     <= 1'b0;
            de_q     <= 1'b0;
            de_out_q <= 1'b0;
        end else begin
            vs_q     <= vs_in;
            hs_q     <= hs_in;
            de_q     <= de_in;
            de_out_q <= de_in & gate;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            w_acc_q    <= '0;
        end else if (acc_clr) begin
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            w_acc_q    <= '0;
        end else if (gate) begin
            if (de_in) begin
                if (pix_cnt_q != CntMax) pix_cnt_q <= pix_cnt_q + CW'(1);
            end else if (de_q) begin
                // End of an active line: the count already holds the final pixel.
                if (line_cnt_q != CntMax) line_cnt_q <= line_cnt_q + CW'(1);
                if (line_cnt_q == '0) w_acc_q <= pix_cnt_q;
                pix_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            meas_w_q     <= '0;
            meas_h_q     <= '0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= frame_end;
            frame_err_q  <= frame_end & ((w_acc_q != ExpW) | (line_cnt_q != ExpH));
            if (frame_end) begin
                meas_w_q    <= w_acc_q;
                meas_h_q    <= line_cnt_q;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

`ifdef VP_FRAME_SKIP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_n_q    <= 4'd0;
            skip_cnt_q  <= 4'd0;
            stop_pend_q <= 1'b0;
        end else begin
            if (state_q == StIdle && start) skip_n_q <= skip_n;
            if (skip_load) begin
                skip_cnt_q <= skip_n_q;
            end else if (skip_dec) begin
                skip_cnt_q <= skip_cnt_q - 4'd1;
            end
            stop_pend_q <= (state_q == StSkip) && (state_d == StSkip) && (stop || stop_pend_q);
        end
    end
`endif

    assign de_out     = de_out_q;
    assign hs_out     = hs_q;
    assign vs_out     = vs_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign meas_w     = meas_w_q;
    assign meas_h     = meas_h_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vp_frame_ctrl.sv
// Self-checking bench for vp_frame_ctrl: directed scenarios plus random frames against a
// frame-level session model.
module tb_vp_frame_ctrl;

    logic        clk;
    logic        rst, de_in, hs_in, vs_in, start, stop, cont;
`ifdef VP_FRAME_SKIP_EN
    logic [3:0]  skip_n;
`endif
    logic        de_out, hs_out, vs_out, busy, frame_done, frame_err;
    logic [10:0] meas_w, meas_h;
    logic [15:0] frame_cnt;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vp_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .de_in      (de_in),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
`ifdef VP_FRAME_SKIP_EN
        .skip_n     (skip_n),
`endif
        .de_out     (de_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .meas_w     (meas_w),
        .meas_h     (meas_h),
        .frame_cnt  (frame_cnt)
    );

    // Monitor: cumulative totals, differenced per frame by the stimulus process.
    bit          mon_en   = 1'b0;
    bit          exp_gate = 1'b0;
    logic        prev_de = 1'b0, prev_hs = 1'b0, prev_vs = 1'b0;
    int          tot_de = 0, tot_mis = 0, tot_done = 0;
    logic [10:0] last_w = '0, last_h = '0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (de_out) tot_de <= tot_de + 1;
            if (de_out !== (prev_de & exp_gate) || hs_out !== prev_hs || vs_out !== prev_vs ||
                (frame_err && !frame_done))
                tot_mis <= tot_mis + 1;
            if (frame_done) begin
                tot_done <= tot_done + 1;
                last_w   <= meas_w;
                last_h   <= meas_h;
                last_err <= frame_err;
            end
        end
        prev_de <= de_in;
        prev_hs <= hs_in;
        prev_vs <= vs_in;
    end

    // Session model
    bit cur_gated = 1'b0, armed = 1'b0, sess_cont = 1'b0, stop_req = 1'b0, pend_valid = 1'b0;
    int proc_cnt = 0;
    int cur_w = 0, cur_h = 0;
    int snap_de = 0, snap_mis = 0, snap_done = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic take_snap();
        snap_de   = tot_de;
        snap_mis  = tot_mis;
        snap_done = tot_done;
    endtask

    task automatic model_start(input bit c);
        if (!cur_gated && !armed) begin
            armed     = 1'b1;
            sess_cont = c;
        end
    endtask

    task automatic model_stop();
        if (cur_gated) stop_req = 1'b1;
        else armed = 1'b0;
    endtask

    task automatic after_reset();
        check_val("rst_de_out", de_out, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_frame_cnt", frame_cnt, 0);
        check_val("rst_meas_w", meas_w, 0);
        cur_gated = 1'b0;
        armed     = 1'b0;
        stop_req  = 1'b0;
        proc_cnt  = 0;
        take_snap();
    endtask

    task automatic close_check(input bit g, input int w, input int h);
        int mw;
        check_val("done_cnt", tot_done - snap_done, g);
        check_val("de_cnt", tot_de - snap_de, g ? w * h : 0);
        check_val("de_mis", tot_mis - snap_mis, 0);
        if (g) begin
            mw = (h == 0) ? 0 : w;
            check_val("meas_w", last_w, mw);
            check_val("meas_h", last_h, h);
            check_val("frame_err", last_err, (mw != 64 || h != 64) ? 1 : 0);
        end
        check_val("frame_cnt", frame_cnt, proc_cnt & 16'hffff);
        check_val("busy", busy, (cur_gated || armed) ? 1 : 0);
    endtask

    // kind: 0 none, 1 stop, 2 reset; event lands mid-line.
    task automatic drive_line(input int w, input bit act, input int kind);
        int ev_px;
        ev_px = (w > 10) ? 10 : w - 1;
        for (int i = 0; i < w; i++) begin
            de_in = act;
            if (kind == 1 && i == ev_px) begin
                stop = 1'b1;
                model_stop();
            end
            if (kind == 2 && i == ev_px) rst = 1'b1;
            tick();
            stop = 1'b0;
            if (rst) begin
                rst      = 1'b0;
                exp_gate = 1'b0;
                after_reset();
            end
        end
        de_in = 1'b0;
        repeat (8) tick();
        hs_in = 1'b1;
        repeat (2) tick();
        hs_in = 1'b0;
        repeat (8) tick();
    endtask

    task automatic send_frame(input int w, input int h, input int ev_line, input int ev_kind,
                              input bit start_vs, input bit start_cont);
        bit closing;
        int cw, ch;
        closing = cur_gated;
        cw      = cur_w;
        ch      = cur_h;
        if (cur_gated) begin
            proc_cnt++;
            cur_gated = sess_cont && !stop_req;
            stop_req  = 1'b0;
        end else begin
            cur_gated = armed;
        end
        armed    = 1'b0;
        exp_gate = cur_gated;
        vs_in    = 1'b1;
        if (start_vs) begin
            start = 1'b1;
            cont  = start_cont;
        end
        tick();
        start = 1'b0;
        if (start_vs) model_start(start_cont);
        tick();
        vs_in = 1'b0;
        tick();
        if (pend_valid) close_check(closing, cw, ch);
        pend_valid = 1'b1;
        cur_w      = w;
        cur_h      = h;
        take_snap();
        repeat (2) drive_line(w, 1'b0, 0);
        for (int l = 0; l < h; l++) drive_line(w, 1'b1, (l == ev_line) ? ev_kind : 0);
    endtask

    task automatic pulse_start(input bit c);
        start = 1'b1;
        cont  = c;
        tick();
        start = 1'b0;
        model_start(c);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        model_stop();
    endtask

    initial begin
        int w, h, evl, evk;
        rst = 1'b1; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        start = 1'b0; stop = 1'b0; cont = 1'b0;
`ifdef VP_FRAME_SKIP_EN
        skip_n = 4'd0;
`endif
        repeat (3) tick();
        check_val("init_de_out", de_out, 0);
        check_val("init_hs_out", hs_out, 0);
        check_val("init_vs_out", vs_out, 0);
        check_val("init_busy", busy, 0);
        check_val("init_done", frame_done, 0);
        check_val("init_err", frame_err, 0);
        check_val("init_meas_w", meas_w, 0);
        check_val("init_meas_h", meas_h, 0);
        check_val("init_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        take_snap();

        // Single 64x64 frame, then an idle frame that closes it.
        pulse_start(1'b0);
        send_frame(64, 64, -1, 0, 1'b0, 1'b0);
        send_frame(40, 2, -1, 0, 1'b0, 1'b0);

        // Reset in the middle of a running frame.
        pulse_start(1'b1);
        send_frame(64, 12, 10, 2, 1'b0, 1'b0);

        // Continuous: three frames, stop during the third; fourth is not gated.
        pulse_start(1'b1);
        send_frame(64, 64, -1, 0, 1'b0, 1'b0);
        send_frame(64, 64, -1, 0, 1'b0, 1'b0);
        send_frame(64, 64, 30, 1, 1'b0, 1'b0);
        send_frame(64, 8, -1, 0, 1'b0, 1'b0);

        // Short frame: height mismatch.
        pulse_start(1'b0);
        send_frame(64, 60, -1, 0, 1'b0, 1'b0);
        send_frame(30, 2, -1, 0, 1'b0, 1'b0);

        // start coincident with vs_rise: processing begins one frame later.
        send_frame(64, 4, -1, 0, 1'b1, 1'b0);
        send_frame(64, 8, -1, 0, 1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(9, 0))
                0, 1, 2: pulse_start($urandom_range(1, 0) == 1);
                3:       pulse_stop();
                default: ;
            endcase
            w   = int'($urandom_range(80, 1));
            h   = int'($urandom_range(10, 0));
            evl = -1;
            evk = 0;
            if (h > 0 && $urandom_range(3, 0) == 0) begin
                evl = int'($urandom_range(h - 1, 0));
                evk = 1;
            end
            send_frame(w, h, evl, evk, 1'b0, 1'b0);
        end
        send_frame(20, 1, -1, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
